// File: rtl/dkong_video_pkg.sv
// Shared Donkey Kong Jr video-path definitions.
// Holds the obj_dma state encoding and the default sprite-attribute block length.
package dkong_video_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        COPY  = 3'd2,
        FLUSH = 3'd3,
        FIN   = 3'd4
    } obj_dma_state_t;

    localparam int OBJ_DMA_LEN = 384;

endpackage

// File: rtl/obj_dma.sv
// Object-RAM DMA: copies LEN bytes from work RAM (1-cycle read latency) into object RAM.
// Define OBJ_DMA_HALT_EN to request the CPU bus (halt_req/halt_ack) before copying.
module obj_dma
    import dkong_video_pkg::*;
#(
    parameter int SRC_ADDR_WIDTH = 11,
    parameter int DST_ADDR_WIDTH = 10,
    parameter int DATA_WIDTH     = 8,
    parameter int LEN            = OBJ_DMA_LEN
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [SRC_ADDR_WIDTH-1:0] src_base,
    output logic [SRC_ADDR_WIDTH-1:0] src_addr,
    output logic                      src_en,
    input  logic [DATA_WIDTH-1:0]     src_q,
    output logic [DST_ADDR_WIDTH-1:0] dst_addr,
    output logic [DATA_WIDTH-1:0]     dst_data,
    output logic                      dst_en,
    output logic                      dst_wren,
    output logic                      busy,
    output logic                      done,
    output logic                      halt_req,
    input  logic                      halt_ack
);

    // One extra bit so that LEN = 2^DST_ADDR_WIDTH fits in the counter.
    localparam int CW = DST_ADDR_WIDTH + 1;
    localparam logic [CW-1:0] LEN_C = CW'(LEN);

`ifdef OBJ_DMA_HALT_EN
    localparam logic HALT_ON = 1'b1;
`else
    localparam logic HALT_ON = 1'b0;
    logic unused_halt_ack;
    assign unused_halt_ack = halt_ack;
`endif

    obj_dma_state_t            state_q, state_d;
    logic [SRC_ADDR_WIDTH-1:0] base_q, base_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [SRC_ADDR_WIDTH-1:0] src_addr_q, src_addr_d;
    logic                      src_en_q, src_en_d;
    logic [DST_ADDR_WIDTH-1:0] dst_addr_q, dst_addr_d;
    logic                      dst_en_q, dst_en_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      halt_req_q, halt_req_d;
    logic                      launch;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            base_q     <= '0;
            cnt_q      <= '0;
            src_addr_q <= '0;
            src_en_q   <= 1'b0;
            dst_addr_q <= '0;
            dst_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            halt_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            cnt_q      <= cnt_d;
            src_addr_q <= src_addr_d;
            src_en_q   <= src_en_d;
            dst_addr_q <= dst_addr_d;
            dst_en_q   <= dst_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            halt_req_q <= halt_req_d;
        end
    end

    // Outputs are computed for the state being entered, so each state's
    // behaviour is visible on the registered outputs while in that state.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        cnt_d      = cnt_q;
        src_addr_d = '0;
        src_en_d   = 1'b0;
        dst_addr_d = '0;
        dst_en_d   = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        halt_req_d = 1'b0;
        launch     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d = src_base;
                    cnt_d  = '0;
`ifdef OBJ_DMA_HALT_EN
                    state_d    = REQ;
                    busy_d     = 1'b1;
                    halt_req_d = 1'b1;
`else
                    launch = 1'b1;
`endif
                end
            end
`ifdef OBJ_DMA_HALT_EN
            REQ: begin
                busy_d     = 1'b1;
                halt_req_d = 1'b1;
                if (halt_ack) begin
                    launch = 1'b1;
                end
            end
`endif
            COPY: begin
                busy_d     = 1'b1;
                halt_req_d = HALT_ON;
                dst_en_d   = 1'b1;
                if (cnt_q == LEN_C) begin
                    state_d    = FLUSH;
                    dst_addr_d = DST_ADDR_WIDTH'(LEN - 1);
                end else begin
                    src_en_d   = 1'b1;
                    src_addr_d = base_q + SRC_ADDR_WIDTH'(cnt_q);
                    dst_addr_d = DST_ADDR_WIDTH'(cnt_q - CW'(1));
                    cnt_d      = cnt_q + CW'(1);
                end
            end
            FLUSH: begin
                state_d = FIN;
                done_d  = 1'b1;
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // First read of a transfer; the counter then points at the next byte.
        if (launch) begin
            state_d    = COPY;
            busy_d     = 1'b1;
            halt_req_d = HALT_ON;
            src_en_d   = 1'b1;
            src_addr_d = base_d;
            cnt_d      = CW'(1);
        end
    end

    assign src_addr = src_addr_q;
    assign src_en   = src_en_q;
    assign dst_addr = dst_addr_q;
    // src_q is already a RAM register; gating keeps dst_data at 0 outside writes.
    assign dst_data = dst_en_q ? src_q : '0;
    assign dst_en   = dst_en_q;
    assign dst_wren = dst_en_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign halt_req = halt_req_q;

endmodule
